// File: rtl/dma_wr_arb.sv
// rtl/dma_wr_arb.sv - credit-limited, quota-weighted round-robin DMA write arbiter (optional stats: DMA_WR_ARB_STATS_EN)
module dma_wr_arb #(
   parameter int N       = 2,
   parameter int W       = 384,
   parameter int CREDITS = 32,
   localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_v,
   output logic [N-1:0]     i_r,
   input  logic [N*W-1:0]   i_m,
   input  logic [N*4-1:0]   cfg_quota,
   output logic             o_v,
   input  logic             o_r,
   output logic [W-1:0]     o_m,
   output logic [SW-1:0]    o_s,
   input  logic             cred_ret,
   output logic [7:0]       outstanding,
   output logic             err_cred
`ifdef DMA_WR_ARB_STATS_EN
   ,
   output logic [N*32-1:0]  stat_grants,
   output logic [31:0]      stat_stall,
   input  logic             stat_clr
`endif
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state;
   logic [SW-1:0]  owner;
   logic [3:0]     bc;

   logic           hs;
   logic [8:0]     cred_sum;
   logic           cred_ok;
   logic           can_issue;
   logic [3:0]     q_raw;
   logic [3:0]     q_eff;
   logic           rr_found;
   logic [SW-1:0]  rr_idx;
   logic           keep;
   logic           gnt_any;
   logic [SW-1:0]  gnt_idx;
   logic           grant;
   logic [W-1:0]   gnt_data;

   assign hs = o_v & o_r;

   // Issue budget counts the beat sitting in the output register, so outstanding can never pass CREDITS
   always_comb begin
      cred_sum  = {1'b0, outstanding} + {8'd0, o_v};
      cred_ok   = (cred_sum < 9'(CREDITS));
      can_issue = (!o_v | o_r) & cred_ok;
   end

   // Current owner's burst quota; a zero quota still allows a single beat
   always_comb begin
      q_raw = cfg_quota[{owner, 2'b00} +: 4];
      q_eff = (q_raw == 4'd0) ? 4'd1 : q_raw;
   end

   // Rotating scan starting just after the owner, owner considered last; lowest offset wins
   always_comb begin
      logic [SW-1:0] jj;
      int            j;
      rr_found = 1'b0;
      rr_idx   = '0;
      jj       = '0;
      for (int k = N; k >= 1; k--) begin
         j = int'(owner) + k;
         if (j >= N) j = j - N;
         jj = SW'(j);
         if (i_v[jj]) begin
            rr_found = 1'b1;
            rr_idx   = jj;
         end
      end
   end

   // Grant decision: keep the owner while it has quota left, otherwise rotate
   always_comb begin
      keep    = (state == HOLD) && i_v[owner] && (bc < q_eff);
      gnt_any = keep || rr_found;
      gnt_idx = keep ? owner : rr_idx;
      grant   = !rst && can_issue && gnt_any;
      i_r     = '0;
      if (grant) i_r[gnt_idx] = 1'b1;
   end

   // Payload mux for the winning requester
   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt_idx == SW'(k)) gnt_data = i_m[k*W +: W];
      end
   end

   // Arbitration state and registered output stage; a stall freezes owner and burst count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         bc    <= '0;
         o_v   <= 1'b0;
         o_m   <= '0;
         o_s   <= '0;
      end else begin
         if (grant) begin
            o_v   <= 1'b1;
            o_m   <= gnt_data;
            o_s   <= gnt_idx;
            owner <= gnt_idx;
            bc    <= keep ? (bc + 4'd1) : 4'd1;
            state <= HOLD;
         end else begin
            if (o_r) o_v <= 1'b0;
            // Issue was allowed but nobody asked: release ownership, keep rotation point
            if (can_issue && (state == HOLD)) state <= IDLE;
         end
      end
   end

   // Outstanding host-write counter with sticky underflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= 8'd0;
         err_cred    <= 1'b0;
      end else begin
         case ({hs, cred_ret})
            2'b10: outstanding <= outstanding + 8'd1;
            2'b01: begin
               if (outstanding == 8'd0) err_cred <= 1'b1;
               else                     outstanding <= outstanding - 8'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef DMA_WR_ARB_STATS_EN
   // Per-source delivered beats and stall cycles; clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants <= '0;
         stat_stall  <= '0;
      end else if (stat_clr) begin
         stat_grants <= '0;
         stat_stall  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (hs && (o_s == SW'(k))) stat_grants[k*32 +: 32] <= stat_grants[k*32 +: 32] + 32'd1;
         end
         if ((o_v && !o_r) || ((|i_v) && !cred_ok)) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dma_wr_arb.sv
// tb/tb_dma_wr_arb.sv - directed table-driven bench for dma_wr_arb (N=2, CREDITS=4)
module tb_dma_wr_arb;

   localparam int N       = 2;
   localparam int W       = 16;
   localparam int CREDITS = 4;
   localparam logic [W-1:0] M0 = 16'hA5A0;
   localparam logic [W-1:0] M1 = 16'h5A51;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    i_v;
   logic [N-1:0]    i_r;
   logic [N*W-1:0]  i_m;
   logic [N*4-1:0]  cfg_quota;
   logic            o_v;
   logic            o_r;
   logic [W-1:0]    o_m;
   logic [0:0]      o_s;
   logic            cred_ret;
   logic [7:0]      outstanding;
   logic            err_cred;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] iv;
      logic       orr;
      logic       cr;
      logic [7:0] q;
      logic [1:0] e_ir;
      logic       e_ov;
      logic       e_os;
      logic [7:0] e_out;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   dma_wr_arb #(.N(N), .W(W), .CREDITS(CREDITS)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_v         (i_v),
      .i_r         (i_r),
      .i_m         (i_m),
      .cfg_quota   (cfg_quota),
      .o_v         (o_v),
      .o_r         (o_r),
      .o_m         (o_m),
      .o_s         (o_s),
      .cred_ret    (cred_ret),
      .outstanding (outstanding),
      .err_cred    (err_cred)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] iv, input logic orr, input logic cr, input logic [7:0] q,
                      input logic [1:0] e_ir, input logic e_ov, input logic e_os,
                      input logic [7:0] e_out, input logic e_err);
      vec_t v;
      v.iv = iv; v.orr = orr; v.cr = cr; v.q = q;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_os = e_os; v.e_out = e_out; v.e_err = e_err;
      vecs.push_back(v);
   endtask

   initial begin
      string nm;
      i_m = {M1, M0};

      // quota {3,3}, both valid: owner=0 after reset so scan starts at 1
      add(2'b11,1,0,8'h33, 2'b10,1,1,8'd0,0);
      add(2'b11,1,0,8'h33, 2'b10,1,1,8'd1,0);
      add(2'b11,1,1,8'h33, 2'b10,1,1,8'd1,0);
      add(2'b11,1,1,8'h33, 2'b01,1,0,8'd1,0);
      add(2'b11,1,1,8'h33, 2'b01,1,0,8'd1,0);
      add(2'b11,1,1,8'h33, 2'b01,1,0,8'd1,0);
      add(2'b11,1,1,8'h33, 2'b10,1,1,8'd1,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd1,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd0,0);
      // credit limit: four handshakes then blocked
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd0,0);
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd1,0);
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd2,0);
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd3,0);
      add(2'b01,1,0,8'h33, 2'b00,0,0,8'd4,0);
      add(2'b01,1,0,8'h33, 2'b00,0,0,8'd4,0);
      add(2'b01,1,1,8'h33, 2'b00,0,0,8'd3,0);
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd3,0);
      add(2'b01,1,0,8'h33, 2'b00,0,0,8'd4,0);
      add(2'b01,1,0,8'h33, 2'b00,0,0,8'd4,0);
      // drain to 2, then simultaneous handshake and cred_ret
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd3,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd2,0);
      add(2'b01,1,0,8'h33, 2'b01,1,0,8'd2,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd2,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd1,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd0,0);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd0,1);
      add(2'b00,1,0,8'h33, 2'b00,0,0,8'd0,1);
      // output stall for 5 cycles, then burst resumes with remaining quota
      add(2'b11,1,0,8'h33, 2'b10,1,1,8'd0,1);
      for (int k = 0; k < 5; k++) add(2'b11,0,0,8'h33, 2'b00,1,1,8'd0,1);
      add(2'b11,1,0,8'h33, 2'b10,1,1,8'd1,1);
      add(2'b11,1,0,8'h33, 2'b10,1,1,8'd2,1);
      add(2'b11,1,0,8'h33, 2'b01,1,0,8'd3,1);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd3,1);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd2,1);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd1,1);
      add(2'b00,1,1,8'h33, 2'b00,0,0,8'd0,1);
      // quota {0,2}: zero quota acts as one; owner drop hands over without a bubble
      add(2'b01,1,0,8'h20, 2'b01,1,0,8'd0,1);
      add(2'b11,1,0,8'h20, 2'b10,1,1,8'd1,1);
      add(2'b11,1,1,8'h20, 2'b10,1,1,8'd1,1);
      add(2'b11,1,1,8'h20, 2'b01,1,0,8'd1,1);
      add(2'b11,1,1,8'h20, 2'b10,1,1,8'd1,1);
      add(2'b01,1,1,8'h20, 2'b01,1,0,8'd1,1);
      add(2'b00,1,1,8'h20, 2'b00,0,0,8'd1,1);
      add(2'b00,1,1,8'h20, 2'b00,0,0,8'd0,1);

      // reset state, with requests already pending
      rst = 1'b1; i_v = 2'b11; o_r = 1'b1; cred_ret = 1'b0; cfg_quota = 8'h33;
      #7;
      chk("rst_i_r", 32'(i_r), 32'd0);
      chk("rst_o_v", 32'(o_v), 32'd0);
      chk("rst_o_m", 32'(o_m), 32'd0);
      chk("rst_o_s", 32'(o_s), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_err", 32'(err_cred), 32'd0);
      i_v = 2'b00;
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         i_v = vecs[i].iv; o_r = vecs[i].orr; cred_ret = vecs[i].cr; cfg_quota = vecs[i].q;
         #1;
         nm = $sformatf("v%0d_i_r", i);
         chk(nm, 32'(i_r), 32'(vecs[i].e_ir));
         @(posedge clk); #1;
         nm = $sformatf("v%0d_o_v", i);
         chk(nm, 32'(o_v), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            nm = $sformatf("v%0d_o_s", i);
            chk(nm, 32'(o_s), 32'(vecs[i].e_os));
            nm = $sformatf("v%0d_o_m", i);
            chk(nm, 32'(o_m), 32'(vecs[i].e_os ? M1 : M0));
         end
         nm = $sformatf("v%0d_outstanding", i);
         chk(nm, 32'(outstanding), 32'(vecs[i].e_out));
         nm = $sformatf("v%0d_err", i);
         chk(nm, 32'(err_cred), 32'(vecs[i].e_err));
      end

      // asynchronous reset in the middle of a burst
      @(negedge clk);
      i_v = 2'b11; o_r = 1'b1; cred_ret = 1'b0; cfg_quota = 8'h33;
      @(posedge clk); #1;
      chk("mid_o_v_a", 32'(o_v), 32'd1);
      chk("mid_o_s_a", 32'(o_s), 32'd1);
      @(posedge clk); #1;
      chk("mid_o_v_b", 32'(o_v), 32'd1);
      chk("mid_out_b", 32'(outstanding), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_o_v", 32'(o_v), 32'd0);
      chk("arst_outstanding", 32'(outstanding), 32'd0);
      chk("arst_err", 32'(err_cred), 32'd0);
      chk("arst_i_r", 32'(i_r), 32'd0);
      chk("arst_o_s", 32'(o_s), 32'd0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("post_rst_i_r", 32'(i_r), 32'b10);
      @(posedge clk); #1;
      chk("post_rst_o_v", 32'(o_v), 32'd1);
      chk("post_rst_o_s", 32'(o_s), 32'd1);
      chk("post_rst_o_m", 32'(o_m), 32'(M1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
